// File: rtl/max_scan_ctrl.sv
// Frame maximum scanner: accepts N samples per started frame and reports the
// largest value (signed or unsigned compare) together with its earliest index.
module max_scan_ctrl #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 16,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iSTART,
    input  logic          iSIGNED,
    input  logic [W-1:0]  iDATA,
    input  logic          iVALID,
    output logic          oREADY,
    output logic          oBUSY,
    output logic          oDONE,
    output logic [W-1:0]  oMAX,
    output logic [IW-1:0] oIDX
);

    localparam int unsigned LAST_IDX = N - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] cnt;
    logic          mode;
    logic          accept;
    logic          last;
    logic          greater;
    logic [W-1:0]  key_data;
    logic [W-1:0]  key_max;

    // Flipping the MSB in signed mode maps two's-complement order onto
    // unsigned order, so a single unsigned comparator serves both modes.
    assign key_data = {iDATA[W-1] ^ mode, iDATA[W-2:0]};
    assign key_max  = {oMAX[W-1] ^ mode, oMAX[W-2:0]};
    assign greater  = key_data > key_max;
    assign accept   = (state == S_SCAN) && iVALID;
    assign last     = cnt == IW'(LAST_IDX);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (iSTART) state_next = S_SCAN;
            S_SCAN:  if (accept && last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oREADY <= 1'b0;
            oBUSY  <= 1'b0;
            oDONE  <= 1'b0;
        end else begin
            oREADY <= state_next == S_SCAN;
            oBUSY  <= state_next != S_IDLE;
            oDONE  <= state_next == S_DONE;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            cnt  <= '0;
            mode <= 1'b0;
            oMAX <= '0;
            oIDX <= '0;
        end else if ((state == S_IDLE) && iSTART) begin
            mode <= iSIGNED;
            cnt  <= '0;
        end else if (accept) begin
            if ((cnt == '0) || greater) begin
                oMAX <= iDATA;
                oIDX <= cnt;
            end
            if (!last) begin
                cnt <= cnt + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Bench for max_scan_ctrl: transaction-level reference (argmax over the
// accepted samples of the current frame) compared every cycle, plus fixed frames.
module tb_max_scan_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sgn;
    logic [W-1:0]  data;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  max_v;
    logic [IW-1:0] idx;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    max_scan_ctrl #(.W(W), .N(N), .IW(IW)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iSIGNED(sgn),
        .iDATA(data), .iVALID(valid), .oREADY(ready), .oBUSY(busy),
        .oDONE(done), .oMAX(max_v), .oIDX(idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: frame phase, latched mode and the list of accepted samples.
    int           m_phase = 0;  // 0 idle, 1 collecting, 2 complete
    logic         m_mode  = 1'b0;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_max = '0;
    int           m_idx = 0;

    function automatic int value_of(input logic [W-1:0] x, input logic s);
        if (s) return int'($signed(x));
        return int'(x);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_mode = 1'b0; m_q.delete(); m_max = '0; m_idx = 0;
        end else begin
            case (m_phase)
                0: if (start) begin m_mode = sgn; m_q.delete(); m_phase = 1; end
                1: if (valid) begin
                    m_q.push_back(data);
                    m_max = m_q[0]; m_idx = 0;
                    foreach (m_q[i])
                        if (value_of(m_q[i], m_mode) > value_of(m_max, m_mode)) begin
                            m_max = m_q[i]; m_idx = i;
                        end
                    if (m_q.size() == N) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        check("ready", int'(ready), int'(m_phase == 1));
        check("busy",  int'(busy),  int'(m_phase != 0));
        check("done",  int'(done),  int'(m_phase == 2));
        check("max",   int'(max_v), int'(m_max));
        check("idx",   int'(idx),   m_idx);
        if (done) n_done++;
    end

    task automatic run_frame(input logic s, input logic [W-1:0] smp[4],
                             input int gap, input logic toggle, input logic hold_start);
        start = 1'b1; sgn = s;
        @(negedge clk);
        start = hold_start;
        if (toggle) sgn = ~s;
        for (int i = 0; i < 4; i++) begin
            repeat (gap) begin valid = 1'b0; @(negedge clk); end
            valid = 1'b1; data = smp[i];
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic expect_done(input string name, input logic [W-1:0] e_max, input int e_idx);
        check({name, "_done"}, int'(done), 1);
        check({name, "_max"},  int'(max_v), int'(e_max));
        check({name, "_idx"},  int'(idx), e_idx);
        @(negedge clk);
        check({name, "_done_gone"}, int'(done), 0);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] s[4];
        int d0;
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; data = '0; valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_max", int'(max_v), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        s = '{8'h10, 8'h80, 8'h7F, 8'h05};
        run_frame(1'b0, s, 0, 1'b0, 1'b0);
        expect_done("unsigned", 8'h80, 1);
        run_frame(1'b1, s, 0, 1'b0, 1'b0);
        expect_done("signed", 8'h7F, 2);
        s = '{8'hF0, 8'h81, 8'hFF, 8'h80};
        run_frame(1'b1, s, 0, 1'b0, 1'b0);
        expect_done("negative", 8'hFF, 2);
        s = '{8'h33, 8'h33, 8'h20, 8'h33};
        d0 = n_done;
        run_frame(1'b0, s, 2, 1'b0, 1'b0);
        expect_done("ties", 8'h33, 0);
        check("ties_one_pulse", n_done - d0, 1);
        s = '{8'h80, 8'h01, 8'h00, 8'h02};
        run_frame(1'b1, s, 0, 1'b1, 1'b0);
        expect_done("mode_latch", 8'h02, 3);
        check("hold_idle_max", int'(max_v), 8'h02);

        // Start held through the whole frame: one frame, then restart from idle.
        s = '{8'h01, 8'h09, 8'h03, 8'h02};
        run_frame(1'b0, s, 1, 1'b0, 1'b1);
        check("held_done", int'(done), 1);
        @(negedge clk);
        check("held_idle", int'(busy), 0);
        @(negedge clk);
        check("held_restart", int'(ready), 1);
        start = 1'b0;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;

        // Reset after two accepted samples, start asserted during reset.
        start = 1'b1; sgn = 1'b0; @(negedge clk); start = 1'b0;
        valid = 1'b1; data = 8'h44; @(negedge clk);
        data = 8'h55; @(negedge clk);
        valid = 1'b0; rst_n = 1'b0; start = 1'b1; @(negedge clk);
        check("abort_max", int'(max_v), 0);
        check("abort_idx", int'(idx), 0);
        check("abort_ready", int'(ready), 0);
        check("abort_busy", int'(busy), 0);
        rst_n = 1'b1; @(negedge clk);
        check("start_after_rst", int'(ready), 1);
        start = 1'b0;

        // Random traffic with occasional resets; the reference follows it.
        for (int k = 0; k < 1500; k++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            start = ($urandom_range(0, 3) == 0);
            sgn   = 1'($urandom_range(0, 1));
            valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: data = 8'h80;
                1: data = 8'h7F;
                2: data = 8'(4 * $urandom_range(0, 3));
                default: data = 8'($urandom);
            endcase
            @(negedge clk);
        end
        rst_n = 1'b1; start = 1'b0; valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
